// File: rtl/gsu_mem_arbiter.sv
// Shared ROM/SaveRAM port sequencer: pending SNES > GSU RAM > GSU ROM (> MCU when built with
// ARB_MCU_PORT_EN), with SCMR RON/RAN bus ownership and substitute data for blocked SNES reads.
module gsu_mem_arbiter #(
  parameter int unsigned MEM_CYCLES    = 4,
  parameter logic [7:0]  SNES_VEC_ODD  = 8'h01,
  parameter logic [7:0]  SNES_VEC_EVEN = 8'h00
) (
  input  logic        CLK,
  input  logic        RST_N,

  input  logic        snes_req,
  input  logic        snes_we,
  input  logic        snes_is_rom,
  input  logic        snes_is_saveram,
  input  logic [23:0] snes_addr,
  input  logic [7:0]  snes_wdata,
  output logic [7:0]  snes_rdata,
  output logic        snes_ack,

  input  logic        scmr_ron,
  input  logic        scmr_ran,
  input  logic [23:0] saveram_mask,

  input  logic        gsu_rom_req,
  input  logic [23:0] gsu_rom_addr,
  output logic [7:0]  gsu_rom_rdata,
  output logic        gsu_rom_ack,

  input  logic        gsu_ram_req,
  input  logic        gsu_ram_we,
  input  logic [16:0] gsu_ram_addr,
  input  logic [7:0]  gsu_ram_wdata,
  output logic [7:0]  gsu_ram_rdata,
  output logic        gsu_ram_ack,

`ifdef ARB_MCU_PORT_EN
  input  logic        mcu_req,
  input  logic        mcu_we,
  input  logic [23:0] mcu_addr,
  input  logic [7:0]  mcu_wdata,
  output logic [7:0]  mcu_rdata,
  output logic        mcu_ack,
`endif

  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_oe,
  output logic        mem_we
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} state_t;
  typedef enum logic [2:0] {SRC_NONE, SRC_SNES, SRC_RAM, SRC_ROM, SRC_MCU} src_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_CYCLES - 1);

  state_t      state;
  src_t        winner;
  logic [3:0]  cnt;

  logic        snes_pend;
  logic [23:0] pend_addr;
  logic        pend_we;
  logic [7:0]  pend_wdata;

  logic        snes_blocked;
  logic        snes_live;
  logic        snes_avail;
  logic [7:0]  snes_vec;
  logic [23:0] ram_mapped;
  src_t        excl;

  src_t        grant;
  logic [23:0] grant_addr;
  logic        grant_we;
  logic [7:0]  grant_wdata;

  // A blocked SNES access is answered locally and never reaches the slot or the memory.
  assign snes_blocked = (snes_is_rom & scmr_ron) | (snes_is_saveram & scmr_ran);
  assign snes_live    = snes_req & ~snes_blocked;
  assign snes_avail   = snes_pend | snes_live;
  assign snes_vec     = snes_is_rom ? (snes_addr[0] ? SNES_VEC_ODD : SNES_VEC_EVEN) : 8'h00;
  assign ram_mapped   = 24'hE00000 | ({7'b0, gsu_ram_addr} & saveram_mask);

  // In DONE the just-finished requester still holds its level request; keep it out.
  assign excl = (state == ST_DONE) ? winner : SRC_NONE;

  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
  always_comb begin
    grant       = SRC_NONE;
    grant_addr  = '0;
    grant_we    = 1'b0;
    grant_wdata = '0;
    if (state != ST_ACC) begin
      if (snes_avail && excl != SRC_SNES) begin
        grant       = SRC_SNES;
        grant_addr  = snes_live ? snes_addr  : pend_addr;
        grant_we    = snes_live ? snes_we    : pend_we;
        grant_wdata = snes_live ? snes_wdata : pend_wdata;
      end else if (gsu_ram_req && scmr_ran && excl != SRC_RAM) begin
        grant       = SRC_RAM;
        grant_addr  = ram_mapped;
        grant_we    = gsu_ram_we;
        grant_wdata = gsu_ram_wdata;
      end else if (gsu_rom_req && scmr_ron && excl != SRC_ROM) begin
        grant       = SRC_ROM;
        grant_addr  = gsu_rom_addr;
      end
`ifdef ARB_MCU_PORT_EN
      else if (mcu_req && excl != SRC_MCU) begin
        grant       = SRC_MCU;
        grant_addr  = mcu_addr;
        grant_we    = mcu_we;
        grant_wdata = mcu_wdata;
      end
`endif
    end
  end

  // NOTE: all state and registered outputs update with non-blocking assignments only.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      winner        <= SRC_NONE;
      cnt           <= '0;
      snes_pend     <= 1'b0;
      pend_addr     <= '0;
      pend_we       <= 1'b0;
      pend_wdata    <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_oe        <= 1'b0;
      mem_we        <= 1'b0;
      snes_rdata    <= '0;
      snes_ack      <= 1'b0;
      gsu_rom_rdata <= '0;
      gsu_rom_ack   <= 1'b0;
      gsu_ram_rdata <= '0;
      gsu_ram_ack   <= 1'b0;
`ifdef ARB_MCU_PORT_EN
      mcu_rdata     <= '0;
      mcu_ack       <= 1'b0;
`endif
    end else begin
      snes_ack    <= 1'b0;
      gsu_rom_ack <= 1'b0;
      gsu_ram_ack <= 1'b0;
`ifdef ARB_MCU_PORT_EN
      mcu_ack     <= 1'b0;
`endif

      // One-deep slot: a newer strobe overwrites it; a grant of the live strobe bypasses it.
      if (snes_live && grant != SRC_SNES) begin
        snes_pend  <= 1'b1;
        pend_addr  <= snes_addr;
        pend_we    <= snes_we;
        pend_wdata <= snes_wdata;
      end else if (grant == SRC_SNES) begin
        snes_pend  <= 1'b0;
      end

      if (snes_req && snes_blocked) begin
        snes_ack <= 1'b1;
        if (!snes_we) snes_rdata <= snes_vec;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (grant != SRC_NONE) begin
            winner    <= grant;
            mem_addr  <= grant_addr;
            mem_wdata <= grant_wdata;
            mem_we    <= grant_we;
            mem_oe    <= ~grant_we;
            cnt       <= CNT_LOAD;
            state     <= ST_ACC;
          end else begin
            state     <= ST_IDLE;
          end
        end
        ST_ACC: begin
          if (cnt == '0) begin
            mem_oe <= 1'b0;
            mem_we <= 1'b0;
            state  <= ST_DONE;
            case (winner)
              SRC_SNES: begin
                snes_ack <= 1'b1;
                if (mem_oe) snes_rdata <= mem_rdata;
              end
              SRC_RAM: begin
                gsu_ram_ack <= 1'b1;
                if (mem_oe) gsu_ram_rdata <= mem_rdata;
              end
              SRC_ROM: begin
                gsu_rom_ack   <= 1'b1;
                gsu_rom_rdata <= mem_rdata;
              end
`ifdef ARB_MCU_PORT_EN
              SRC_MCU: begin
                mcu_ack <= 1'b1;
                if (mem_oe) mcu_rdata <= mem_rdata;
              end
`endif
              default: ;
            endcase
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsu_mem_arbiter.sv
// Self-checking bench for gsu_mem_arbiter: SNES vector table, directed corner sequences and
// randomized episodes checked against a transaction-level memory/ownership model.
module tb_gsu_mem_arbiter;

  localparam int MC = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        snes_req = 1'b0, snes_we = 1'b0, snes_is_rom = 1'b0, snes_is_saveram = 1'b0;
  logic [23:0] snes_addr = '0;
  logic [7:0]  snes_wdata = '0;
  logic [7:0]  snes_rdata;
  logic        snes_ack;
  logic        scmr_ron = 1'b0, scmr_ran = 1'b0;
  logic [23:0] saveram_mask = 24'h01FFFF;
  logic        gsu_rom_req = 1'b0;
  logic [23:0] gsu_rom_addr = '0;
  logic [7:0]  gsu_rom_rdata;
  logic        gsu_rom_ack;
  logic        gsu_ram_req = 1'b0, gsu_ram_we = 1'b0;
  logic [16:0] gsu_ram_addr = '0;
  logic [7:0]  gsu_ram_wdata = '0;
  logic [7:0]  gsu_ram_rdata;
  logic        gsu_ram_ack;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_oe, mem_we;

  logic        force_en = 1'b0;
  logic [7:0]  force_val = '0;
  logic        snes_busy = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  gsu_mem_arbiter #(.MEM_CYCLES(MC)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .snes_req(snes_req), .snes_we(snes_we), .snes_is_rom(snes_is_rom),
    .snes_is_saveram(snes_is_saveram), .snes_addr(snes_addr), .snes_wdata(snes_wdata),
    .snes_rdata(snes_rdata), .snes_ack(snes_ack),
    .scmr_ron(scmr_ron), .scmr_ran(scmr_ran), .saveram_mask(saveram_mask),
    .gsu_rom_req(gsu_rom_req), .gsu_rom_addr(gsu_rom_addr), .gsu_rom_rdata(gsu_rom_rdata),
    .gsu_rom_ack(gsu_rom_ack),
    .gsu_ram_req(gsu_ram_req), .gsu_ram_we(gsu_ram_we), .gsu_ram_addr(gsu_ram_addr),
    .gsu_ram_wdata(gsu_ram_wdata), .gsu_ram_rdata(gsu_ram_rdata), .gsu_ram_ack(gsu_ram_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_oe(mem_oe), .mem_we(mem_we)
  );

  // Memory model: content is a fixed function of the address.
  function automatic logic [7:0] mem_hash(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h5A;
  endfunction

  assign mem_rdata = force_en ? force_val : mem_hash(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // New SNES strobe while the previous unblocked one is still outstanding is a protocol error.
  always @(posedge CLK)
    assert (!(snes_req && snes_busy)) else $error("snes overrun: strobe while access outstanding");

  // Strobe-window monitor: records each completed memory access.
  logic        in_win = 1'b0;
  logic [23:0] win_addr = '0, last_addr = '0;
  logic        win_we = 1'b0, last_we = 1'b0;
  logic [7:0]  win_wdata = '0, last_wdata = '0;
  int          win_len = 0, last_len = 0, win_count = 0;

  always begin
    @(posedge CLK);
    #1;
    if (mem_oe || mem_we) begin
      check("strobe_exclusive", 32'(mem_oe & mem_we), 32'd0);
      if (!in_win) begin
        in_win = 1'b1; win_addr = mem_addr; win_we = mem_we; win_wdata = mem_wdata; win_len = 1;
      end else begin
        win_len++;
        check("addr_stable", mem_addr, win_addr);
        check("wdata_stable", mem_wdata, win_wdata);
      end
    end else if (in_win) begin
      in_win = 1'b0;
      last_addr = win_addr; last_we = win_we; last_wdata = win_wdata; last_len = win_len;
      win_count++;
    end
  end

  task automatic check_window(input string tag, input logic [23:0] a, input logic we,
                              input logic [7:0] wd);
    check({tag, "_win_addr"}, last_addr, a);
    check({tag, "_win_we"}, 32'(last_we), 32'(we));
    check({tag, "_win_len"}, last_len, MC);
    if (we) check({tag, "_win_wdata"}, last_wdata, wd);
  endtask

  task automatic gsu_rom_txn(input logic [23:0] a, input int bound);
    int got;
    got = 0;
    gsu_rom_addr = a; gsu_rom_req = 1'b1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (gsu_rom_ack) begin got = 1; break; end
    end
    gsu_rom_req = 1'b0;
    check("rom_ack_seen", got, 1);
    if (got != 0) begin
      check("rom_rdata", gsu_rom_rdata, mem_hash(a));
      check_window("rom", a, 1'b0, 8'h00);
    end
  endtask

  task automatic gsu_ram_txn(input logic [16:0] a, input logic we, input logic [7:0] wd,
                             input int bound);
    int got;
    logic [23:0] ea;
    got = 0;
    ea = 24'hE00000 | ({7'b0, a} & saveram_mask);
    gsu_ram_addr = a; gsu_ram_we = we; gsu_ram_wdata = wd; gsu_ram_req = 1'b1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (gsu_ram_ack) begin got = 1; break; end
    end
    gsu_ram_req = 1'b0;
    check("ram_ack_seen", got, 1);
    if (got != 0) begin
      if (!we) check("ram_rdata", gsu_ram_rdata, mem_hash(ea));
      check_window("ram", ea, we, wd);
    end
  endtask

  task automatic snes_txn(input logic rom, input logic [23:0] a, input logic we,
                          input logic [7:0] wd, input int bound, output int lat, output logic blk);
    blk = rom ? scmr_ron : scmr_ran;
    snes_is_rom = rom; snes_is_saveram = ~rom; snes_addr = a; snes_we = we; snes_wdata = wd;
    snes_req = 1'b1;
    lat = 0;
    tick();
    snes_req = 1'b0;
    if (!blk) snes_busy = 1'b1;
    for (int i = 1; i <= bound; i++) begin
      if (snes_ack) begin lat = i; break; end
      tick();
    end
    snes_busy = 1'b0;
    check("snes_ack_seen", 32'(lat != 0), 32'd1);
    if (blk) begin
      check("snes_blocked_lat", lat, 1);
      if (!we) check("snes_blocked_rdata", snes_rdata, rom ? (a[0] ? 8'h01 : 8'h00) : 8'h00);
    end else if (lat != 0) begin
      if (!we) check("snes_rdata", snes_rdata, mem_hash(a));
      check_window("snes", a, we, wd);
    end
  endtask

  typedef struct {
    logic        rom;
    logic        ron;
    logic        ran;
    logic [23:0] addr;
    logic        we;
    logic [7:0]  wd;
    int          exp_lat;
    logic        chk_rdata;
    logic [7:0]  exp_rdata;
    int          exp_windows;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int lat, w0, acks, strobes, rom_at, snes_at, ram_at;
    logic blk;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 24'h00FFEE, 1'b0, 8'h00, 1,    1'b1, 8'h00, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 24'h00FFEF, 1'b0, 8'h00, 1,    1'b1, 8'h01, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 24'h700010, 1'b0, 8'h00, 1,    1'b1, 8'h00, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 24'h700011, 1'b1, 8'h77, 1,    1'b0, 8'h00, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 24'h123456, 1'b0, 8'h00, MC+1, 1'b1, mem_hash(24'h123456), 1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 24'h7001FE, 1'b1, 8'hAA, MC+1, 1'b0, 8'h00, 1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 24'h700201, 1'b0, 8'h00, MC+1, 1'b1, mem_hash(24'h700201), 1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 24'h3FFFFF, 1'b0, 8'h00, MC+1, 1'b1, mem_hash(24'h3FFFFF), 1};

    // Reset state
    tick(); tick();
    check("reset_mem_addr", mem_addr, 24'h0);
    check("reset_strobes_acks", {mem_oe, mem_we, snes_ack, gsu_rom_ack, gsu_ram_ack}, 0);
    check("reset_rdata", {snes_rdata, gsu_rom_rdata, gsu_ram_rdata}, 0);
    check("reset_wdata", mem_wdata, 0);
    RST_N = 1'b1;
    tick();

    // SNES vector table, each access uncontended
    foreach (vecs[i]) begin
      scmr_ron = vecs[i].ron; scmr_ran = vecs[i].ran;
      tick();
      w0 = win_count;
      snes_txn(vecs[i].rom, vecs[i].addr, vecs[i].we, vecs[i].wd, 20, lat, blk);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      if (vecs[i].chk_rdata) check($sformatf("vec%0d_rdata", i), snes_rdata, vecs[i].exp_rdata);
      tick(); tick();
      check($sformatf("vec%0d_windows", i), win_count - w0, vecs[i].exp_windows);
    end

    // Uncontended GSU ROM read
    scmr_ron = 1'b1; scmr_ran = 1'b0; force_en = 1'b1; force_val = 8'hA5;
    gsu_rom_addr = 24'h012345; gsu_rom_req = 1'b1;
    for (int k = 1; k <= MC + 1; k++) begin
      tick();
      if (k <= MC) begin
        check($sformatf("rom_oe_c%0d", k), 32'(mem_oe), 32'd1);
        check($sformatf("rom_addr_c%0d", k), mem_addr, 24'h012345);
        check($sformatf("rom_noack_c%0d", k), 32'(gsu_rom_ack), 32'd0);
      end else begin
        check("rom_ack_c5", 32'(gsu_rom_ack), 32'd1);
        check("rom_rdata_a5", gsu_rom_rdata, 8'hA5);
        check("rom_oe_off_c5", 32'(mem_oe), 32'd0);
      end
    end
    gsu_rom_req = 1'b0; force_en = 1'b0;
    tick(); tick();

    // RAM masking write
    scmr_ran = 1'b1; saveram_mask = 24'h007FFF;
    gsu_ram_addr = 17'h1ABCD; gsu_ram_we = 1'b1; gsu_ram_wdata = 8'h3C; gsu_ram_req = 1'b1;
    for (int k = 1; k <= MC + 1; k++) begin
      tick();
      if (k <= MC) begin
        check($sformatf("ram_we_c%0d", k), {mem_we, mem_oe}, 2'b10);
        check($sformatf("ram_addr_c%0d", k), mem_addr, 24'hE02BCD);
        check($sformatf("ram_wdata_c%0d", k), mem_wdata, 8'h3C);
      end else begin
        check("ram_ack_c5", 32'(gsu_ram_ack), 32'd1);
      end
    end
    gsu_ram_req = 1'b0; gsu_ram_we = 1'b0;
    tick(); tick();

    // Contention: ROM in progress, then SNES and GSU RAM arrive together
    scmr_ron = 1'b1; scmr_ran = 1'b1; saveram_mask = 24'h01FFFF;
    gsu_rom_addr = 24'h000100; gsu_rom_req = 1'b1;
    tick();
    scmr_ron = 1'b0;
    snes_is_rom = 1'b1; snes_is_saveram = 1'b0; snes_we = 1'b0; snes_addr = 24'h004000;
    snes_req = 1'b1;
    gsu_ram_addr = 17'h00040; gsu_ram_we = 1'b0; gsu_ram_req = 1'b1;
    rom_at = -1; snes_at = -1; ram_at = -1;
    for (int c = 2; c <= 30; c++) begin
      tick();
      snes_req = 1'b0;
      if (gsu_rom_ack) begin rom_at = c; gsu_rom_req = 1'b0; end
      if (snes_ack) snes_at = c;
      if (gsu_ram_ack) begin ram_at = c; gsu_ram_req = 1'b0; end
      if (c == 7) check("cont_snes_addr", mem_addr, 24'h004000);
    end
    check("cont_rom_ack_at", rom_at, MC + 1);
    check("cont_snes_ack_at", snes_at, 2 * (MC + 1));
    check("cont_ram_ack_at", ram_at, 3 * (MC + 1));
    check("cont_snes_rdata", snes_rdata, mem_hash(24'h004000));
    check("cont_ram_rdata", gsu_ram_rdata, mem_hash(24'hE00040));
    check("cont_rom_rdata_hold", gsu_rom_rdata, mem_hash(24'h000100));

    // Stall while RAN=0, then release
    scmr_ron = 1'b0; scmr_ran = 1'b0;
    gsu_ram_addr = 17'h00010; gsu_ram_we = 1'b0; gsu_ram_req = 1'b1;
    acks = 0; strobes = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (gsu_ram_ack) acks++;
      if (mem_oe || mem_we) strobes++;
    end
    check("stall_no_ack", acks, 0);
    check("stall_no_strobe", strobes, 0);
    scmr_ran = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (gsu_ram_ack) begin lat = c; break; end
    end
    gsu_ram_req = 1'b0;
    check("stall_release_lat", lat, MC + 1);
    tick(); tick();

    // Reset in the middle of an access
    scmr_ron = 1'b1;
    gsu_rom_addr = 24'h0000AA; gsu_rom_req = 1'b1;
    tick(); tick();
    check("midrst_pre_oe", 32'(mem_oe), 32'd1);
    #1 RST_N = 1'b0;
    #1 check("midrst_strobes_drop", {mem_oe, mem_we}, 2'b00);
    gsu_rom_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (gsu_rom_ack) acks++;
    end
    check("midrst_outputs_zero", {mem_addr, mem_oe, mem_we, snes_ack, gsu_rom_ack, gsu_ram_ack}, 0);
    check("midrst_rdata_zero", {snes_rdata, gsu_rom_rdata, gsu_ram_rdata}, 0);
    RST_N = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (gsu_rom_ack) acks++;
    end
    check("midrst_no_ack", acks, 0);

    // Randomized episodes
    for (int ep = 0; ep < 30; ep++) begin
      logic en_rom, en_ram, en_snes, s_rom, s_we, r_we;
      logic [23:0] r_addr, s_addr;
      logic [16:0] m_addr;
      logic [7:0]  r_wd, s_wd;
      int d_ram, d_snes, m_sel;
      scmr_ron = 1'($urandom_range(0, 1));
      scmr_ran = 1'($urandom_range(0, 1));
      m_sel = $urandom_range(0, 2);
      saveram_mask = (m_sel == 0) ? 24'h001FFF : (m_sel == 1) ? 24'h007FFF : 24'h01FFFF;
      en_rom = 1'($urandom_range(0, 1)); en_ram = 1'($urandom_range(0, 1));
      en_snes = 1'($urandom_range(0, 1));
      r_addr = 24'($urandom); m_addr = 17'($urandom); s_addr = 24'($urandom);
      r_we = 1'($urandom_range(0, 1)); r_wd = 8'($urandom);
      s_rom = 1'($urandom_range(0, 1)); s_we = 1'($urandom_range(0, 1)); s_wd = 8'($urandom);
      d_ram = $urandom_range(0, 3); d_snes = $urandom_range(0, 6);
      tick();
      fork
        begin : p_rom
          if (en_rom) gsu_rom_txn(r_addr, 120);
        end
        begin : p_ram
          if (en_ram) begin
            repeat (d_ram) tick();
            gsu_ram_txn(m_addr, r_we, r_wd, 120);
          end
        end
        begin : p_snes
          int s_lat;
          logic s_blk;
          if (en_snes) begin
            repeat (d_snes) tick();
            snes_txn(s_rom, s_addr, s_we, s_wd, 40, s_lat, s_blk);
          end
        end
        begin : p_own
          repeat (30) tick();
          scmr_ron = 1'b1; scmr_ran = 1'b1;
        end
      join
      tick(); tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
